alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 30 +++
 rtl/alu_exec_unit_alu_ctrl_decode.sv | 30 +++
 rtl/alu_exec_unit.sv | 101 ++++++++++
 tb/tb_alu_exec_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared encodings for the MIPS execute-stage ALU: control codes, ALUop and funct values.
package alu_exec_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FUNCT_W = 6;

  typedef logic [CTRL_W-1:0] alu_ctrl_t;

  localparam alu_ctrl_t CTRL_AND = 3'b000;
  localparam alu_ctrl_t CTRL_OR  = 3'b001;
  localparam alu_ctrl_t CTRL_ADD = 3'b010;
  localparam alu_ctrl_t CTRL_SUB = 3'b110;
  localparam alu_ctrl_t CTRL_SLT = 3'b111;
  localparam alu_ctrl_t CTRL_NOR = 3'b100;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD     = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB     = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD_ALT = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_exec_unit_alu_ctrl_decode.sv
// Combinational ALU control decode from main-control ALUop and instruction funct.
module alu_ctrl_decode
  import alu_exec_pkg::*;
(
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output alu_ctrl_t          ctrl_c
);

  // funct only matters for R-type; unknown funct values fall back to ADD
  always_comb begin
    ctrl_c = CTRL_ADD;
    case (alu_op)
      ALUOP_SUB: ctrl_c = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl_c = CTRL_ADD;
          FUNCT_SUB: ctrl_c = CTRL_SUB;
          FUNCT_AND: ctrl_c = CTRL_AND;
          FUNCT_OR:  ctrl_c = CTRL_OR;
          FUNCT_SLT: ctrl_c = CTRL_SLT;
          FUNCT_NOR: ctrl_c = CTRL_NOR;
          default:   ctrl_c = CTRL_ADD;
        endcase
      end
      default: ctrl_c = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU, zero flag and branch-target adder registered into EX/MEM.
// Optional signed-overflow output is built when ALU_OVF_EN is defined.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic                alu_src,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [DATA_W-1:0]   reg_data1,
  input  logic [DATA_W-1:0]   reg_data2,
  input  logic [DATA_W-1:0]   sign_ext_offset,
  input  logic [DATA_W-1:0]   incremented_pc,
  output logic [DATA_W-1:0]   alu_result,
  output logic                zero_flag,
  output logic [DATA_W-1:0]   branch_address,
  output logic [CTRL_W-1:0]   alu_ctrl
`ifdef ALU_OVF_EN
  ,
  output logic                overflow
`endif
);

  alu_ctrl_t           ctrl_c;
  logic [DATA_W-1:0]   op_b_c;
  logic [DATA_W-1:0]   sum_c;
  logic [DATA_W-1:0]   diff_c;
  logic                slt_c;
  logic [DATA_W-1:0]   result_c;
  logic [DATA_W-1:0]   branch_c;

  alu_ctrl_decode u_decode (
    .alu_op (alu_op),
    .funct  (funct),
    .ctrl_c (ctrl_c)
  );

  assign op_b_c = alu_src ? sign_ext_offset : reg_data2;
  assign sum_c  = reg_data1 + op_b_c;
  assign diff_c = reg_data1 + (~op_b_c) + DATA_W'(1);

  // Differing signs decide SLT directly, so an overflowing subtract cannot flip it
  assign slt_c = (reg_data1[DATA_W-1] ^ op_b_c[DATA_W-1]) ? reg_data1[DATA_W-1]
                                                           : diff_c[DATA_W-1];

  always_comb begin
    result_c = sum_c;
    case (ctrl_c)
      CTRL_AND: result_c = reg_data1 & op_b_c;
      CTRL_OR:  result_c = reg_data1 | op_b_c;
      CTRL_ADD: result_c = sum_c;
      CTRL_SUB: result_c = diff_c;
      CTRL_SLT: result_c = {(DATA_W-1)'(0), slt_c};
      CTRL_NOR: result_c = ~(reg_data1 | op_b_c);
      default:  result_c = sum_c;
    endcase
  end

  assign branch_c = incremented_pc + {sign_ext_offset[DATA_W-3:0], 2'b00};

`ifdef ALU_OVF_EN
  logic ovf_c;

  always_comb begin
    ovf_c = 1'b0;
    case (ctrl_c)
      CTRL_ADD: ovf_c = (reg_data1[DATA_W-1] == op_b_c[DATA_W-1]) &&
                        (sum_c[DATA_W-1] != reg_data1[DATA_W-1]);
      CTRL_SUB: ovf_c = (reg_data1[DATA_W-1] != op_b_c[DATA_W-1]) &&
                        (diff_c[DATA_W-1] != reg_data1[DATA_W-1]);
      default:  ovf_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (en) begin
      overflow <= ovf_c;
    end
  end
`endif

  // EX/MEM boundary registers; reset wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result     <= '0;
      zero_flag      <= 1'b0;
      branch_address <= '0;
      alu_ctrl       <= CTRL_ADD;
    end else if (en) begin
      alu_result     <= result_c;
      zero_flag      <= (result_c == '0);
      branch_address <= branch_c;
      alu_ctrl       <= ctrl_c;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: vector table plus reset/hold sequences.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [5:0]  funct;
  logic [31:0] reg_data1;
  logic [31:0] reg_data2;
  logic [31:0] sign_ext_offset;
  logic [31:0] incremented_pc;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] branch_address;
  logic [2:0]  alu_ctrl;
`ifdef ALU_OVF_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  alu_exec_unit dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .alu_op          (alu_op),
    .alu_src         (alu_src),
    .funct           (funct),
    .reg_data1       (reg_data1),
    .reg_data2       (reg_data2),
    .sign_ext_offset (sign_ext_offset),
    .incremented_pc  (incremented_pc),
    .alu_result      (alu_result),
    .zero_flag       (zero_flag),
    .branch_address  (branch_address),
    .alu_ctrl        (alu_ctrl)
`ifdef ALU_OVF_EN
    ,
    .overflow        (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] off;
    logic [31:0] pc;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic [31:0] exp_br;
    logic [2:0]  exp_ctrl;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  // funct always mirrors the low offset bits, as in a real instruction word
  task automatic drive(input logic [1:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] off, input logic [31:0] pc);
    alu_op          = op;
    alu_src         = src;
    reg_data1       = a;
    reg_data2       = b;
    sign_ext_offset = off;
    funct           = off[5:0];
    incremented_pc  = pc;
  endtask

  task automatic check_all(input string name, input int idx, input logic [31:0] res,
                           input logic z, input logic [31:0] br, input logic [2:0] c,
                           input logic ovf);
    chk({name, ".result"}, idx, alu_result, res);
    chk({name, ".zero"}, idx, 32'(zero_flag), 32'(z));
    chk({name, ".branch"}, idx, branch_address, br);
    chk({name, ".ctrl"}, idx, 32'(alu_ctrl), 32'(c));
`ifdef ALU_OVF_EN
    chk({name, ".ovf"}, idx, 32'(overflow), 32'(ovf));
`else
    if (ovf === 1'bx) $display("unexpected x");
`endif
  endtask

  initial begin
    // op, src, a, b, off(funct=off[5:0]), pc, result, zero, branch, ctrl, ovf
    vecs[0]  = '{2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, 32'h24, 32'h100, 32'h0000_0000, 1'b1, 32'h190, 3'b000, 1'b0};
    vecs[1]  = '{2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, 32'h25, 32'h100, 32'h0000_0FFF, 1'b0, 32'h194, 3'b001, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, 32'h20, 32'h100, 32'h0000_0FFF, 1'b0, 32'h180, 3'b010, 1'b0};
    vecs[3]  = '{2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, 32'h22, 32'h100, 32'hFFFF_F1E1, 1'b0, 32'h188, 3'b110, 1'b0};
    vecs[4]  = '{2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, 32'h27, 32'h100, 32'hFFFF_F000, 1'b0, 32'h19C, 3'b100, 1'b0};
    vecs[5]  = '{2'b10, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h2A, 32'h100, 32'h0000_0001, 1'b0, 32'h1A8, 3'b111, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h2A, 32'h100, 32'h0000_0000, 1'b1, 32'h1A8, 3'b111, 1'b0};
    vecs[7]  = '{2'b10, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h2A, 32'h0,   32'h0000_0001, 1'b0, 32'hA8,  3'b111, 1'b0};
    vecs[8]  = '{2'b01, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'hFFFF_FFFE, 32'd40, 32'h0, 1'b1, 32'd32, 3'b110, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 32'd3, 32'd4, 32'h0, 32'h8, 32'd7, 1'b0, 32'h8, 3'b010, 1'b0};
    vecs[10] = '{2'b10, 1'b0, 32'd1, 32'd1, 32'h3F, 32'h0, 32'd2, 1'b0, 32'hFC, 3'b010, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 32'd10, 32'd3, 32'h22, 32'h0, 32'd13, 1'b0, 32'h88, 3'b010, 1'b0};
    vecs[12] = '{2'b01, 1'b0, 32'd5, 32'd7, 32'h4, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 1'b0, 32'hC, 3'b110, 1'b0};
    vecs[13] = '{2'b00, 1'b1, 32'd0, 32'd9, 32'h4000_0001, 32'h10, 32'h4000_0001, 1'b0, 32'h14, 3'b010, 1'b0};
    vecs[14] = '{2'b00, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h8000_0000, 1'b0, 32'h0, 3'b010, 1'b1};
    vecs[15] = '{2'b00, 1'b1, 32'd100, 32'd55, 32'hFFFF_FFFC, 32'h200, 32'd96, 1'b0, 32'h1F0, 3'b010, 1'b0};

    // Reset with arbitrary inputs for two cycles
    rst = 1'b1;
    en  = 1'b1;
    drive(2'b10, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0022, 32'hCAFE_0000);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 32'h0, 1'b0, 32'h0, 3'b010, 1'b0);

    // First capture after reset release
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check_all("post_reset", 0, 32'd12, 1'b0, 32'h0, 3'b010, 1'b0);

    // Back-to-back table vectors, one per cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].pc);
      @(posedge clk);
      #1;
      check_all("vec", i, vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_br,
                vecs[i].exp_ctrl, vecs[i].exp_ovf);
    end

    // Hold for three cycles with en low and different inputs
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en = 1'b0;
      drive(2'b01, 1'b0, 32'd1000 + 32'(k), 32'd1, 32'h0000_0010, 32'h4000);
      @(posedge clk);
      #1;
      check_all("hold", k, 32'd96, 1'b0, 32'h1F0, 3'b010, 1'b0);
    end

    // Reset mid-stream discards the in-flight op, even with en high
    @(negedge clk);
    en  = 1'b1;
    rst = 1'b1;
    drive(2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, 32'h25, 32'h100);
    @(posedge clk);
    #1;
    check_all("mid_reset", 0, 32'h0, 1'b0, 32'h0, 3'b010, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    drive(2'b10, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, 32'h22, 32'h100);
    @(posedge clk);
    #1;
    check_all("resume", 0, 32'hFFFF_F1E1, 1'b0, 32'h188, 3'b110, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
